mem_access: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result, store data and destination-register info.
- For loads and stores, runs a valid/ready transaction on the data-memory bus, stalling upstream until it completes.
- For loads, aligns and sign- or zero-extends the read data; produces registered writeback outputs.

---
 rtl/mem_access.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access : load/store stage between execute and writeback
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_access #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        req,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] result_in,
   input  logic [31:0] rs2_value_in,
   input  logic [4:0]  rd_in,
   output logic        stall_out,
   output logic        dmem_valid,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_rd_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_out,
   output logic        bus_err_out
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BUSY  = 1'b1;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [0:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        dmem_valid_q, dmem_valid_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_rd_write_q, wb_rd_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        is_load, is_store, is_mem, access_ok, start_access, timeout_hit;
   logic [3:0]  access_be;
   logic [31:0] store_wdata, lane_word, load_data;

   assign is_load  = (opcode_in == OP_LOAD);
   assign is_store = (opcode_in == OP_STORE);
   assign is_mem   = is_load | is_store;

   // Undefined size/sign encodings are dropped the same way as misaligned ones.
   always_comb begin
      access_ok = 1'b0;
      case (funct3_in)
         3'b000, 3'b100: access_ok = 1'b1;
         3'b001, 3'b101: access_ok = ~result_in[0];
         3'b010:         access_ok = (result_in[1:0] == 2'b00);
         default:        access_ok = 1'b0;
      endcase
      if (is_store && funct3_in[2]) begin
         access_ok = 1'b0;
      end
   end

   assign start_access = (state_q == ST_IDLE) && in_valid && is_mem && access_ok;
   assign timeout_hit  = (state_q == ST_BUSY) && !dmem_ready && (cnt_q == CNT_LAST);

   always_comb begin
      case (funct3_in[1:0])
         2'b00: begin
            access_be   = 4'b0001 << result_in[1:0];
            store_wdata = {4{rs2_value_in[7:0]}};
         end
         2'b01: begin
            access_be   = result_in[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{rs2_value_in[15:0]}};
         end
         default: begin
            access_be   = 4'b1111;
            store_wdata = rs2_value_in;
         end
      endcase
   end

   // Shifting the selected lane down to bit 0 serves every load size.
   always_comb begin
      lane_word = dmem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
         3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
         3'b100:  load_data = {24'h0, lane_word[7:0]};
         3'b101:  load_data = {16'h0, lane_word[15:0]};
         default: load_data = lane_word;
      endcase
   end

   always_ff @(posedge req or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_access) state_d = ST_BUSY;
         ST_BUSY: if (dmem_ready || timeout_hit) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A timed-out access also releases upstream, otherwise the same
   // instruction would be re-issued from IDLE.
   always_comb begin
      stall_out = 1'b0;
      case (state_q)
         ST_IDLE: stall_out = start_access;
         ST_BUSY: stall_out = !(dmem_ready || timeout_hit);
         default: stall_out = 1'b0;
      endcase
   end

   always_comb begin
      cnt_d         = cnt_q;
      dmem_valid_d  = dmem_valid_q;
      dmem_we_d     = dmem_we_q;
      dmem_addr_d   = dmem_addr_q;
      dmem_be_d     = dmem_be_q;
      dmem_wdata_d  = dmem_wdata_q;
      off_d         = off_q;
      funct3_d      = funct3_q;
      rd_d          = rd_q;
      wb_valid_d    = 1'b0;
      wb_rd_write_d = wb_rd_write_q;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      misalign_d    = 1'b0;
      bus_err_d     = 1'b0;
      if (state_q == ST_IDLE) begin
         if (in_valid && !is_mem) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = result_in;
            wb_rd_d       = rd_in;
            wb_rd_write_d = (rd_in != 5'd0);
         end else if (in_valid && !access_ok) begin
            misalign_d    = 1'b1;
            wb_valid_d    = 1'b1;
            wb_rd_d       = rd_in;
            wb_rd_write_d = 1'b0;
         end else if (start_access) begin
            cnt_d        = 8'd0;
            dmem_valid_d = 1'b1;
            dmem_we_d    = is_store;
            dmem_addr_d  = {result_in[31:2], 2'b00};
            dmem_be_d    = access_be;
            dmem_wdata_d = is_store ? store_wdata : 32'h0;
            off_d        = result_in[1:0];
            funct3_d     = funct3_in;
            rd_d         = rd_in;
         end
      end else begin
         if (dmem_ready) begin
            dmem_valid_d  = 1'b0;
            wb_valid_d    = 1'b1;
            wb_rd_d       = rd_q;
            wb_rd_write_d = !dmem_we_q && (rd_q != 5'd0);
            if (!dmem_we_q) begin
               wb_data_d = load_data;
            end
         end else if (timeout_hit) begin
            dmem_valid_d  = 1'b0;
            bus_err_d     = 1'b1;
            wb_valid_d    = 1'b1;
            wb_rd_d       = rd_q;
            wb_rd_write_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge req or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= 8'd0;
         dmem_valid_q  <= 1'b0;
         dmem_we_q     <= 1'b0;
         dmem_addr_q   <= 32'h0;
         dmem_be_q     <= 4'h0;
         dmem_wdata_q  <= 32'h0;
         off_q         <= 2'b00;
         funct3_q      <= 3'b000;
         rd_q          <= 5'd0;
         wb_valid_q    <= 1'b0;
         wb_rd_write_q <= 1'b0;
         wb_rd_q       <= 5'd0;
         wb_data_q     <= 32'h0;
         misalign_q    <= 1'b0;
         bus_err_q     <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         dmem_valid_q  <= dmem_valid_d;
         dmem_we_q     <= dmem_we_d;
         dmem_addr_q   <= dmem_addr_d;
         dmem_be_q     <= dmem_be_d;
         dmem_wdata_q  <= dmem_wdata_d;
         off_q         <= off_d;
         funct3_q      <= funct3_d;
         rd_q          <= rd_d;
         wb_valid_q    <= wb_valid_d;
         wb_rd_write_q <= wb_rd_write_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         misalign_q    <= misalign_d;
         bus_err_q     <= bus_err_d;
      end
   end

   assign dmem_valid   = dmem_valid_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_be      = dmem_be_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd_write  = wb_rd_write_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_out = misalign_q;
   assign bus_err_out  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_access : randomized bench for mem_access against a transaction model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_access;

   localparam int T = 4;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   logic        req = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  opcode_in = 7'h0;
   logic [2:0]  funct3_in = 3'h0;
   logic [31:0] result_in = 32'h0;
   logic [31:0] rs2_value_in = 32'h0;
   logic [4:0]  rd_in = 5'h0;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;
   logic        stall_out, dmem_valid, dmem_we, wb_valid, wb_rd_write;
   logic        misalign_out, bus_err_out;
   logic [31:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  dmem_be;
   logic [4:0]  wb_rd;

   int n_cmp = 0;
   int n_err = 0;

   always #5 req = ~req;

   mem_access #(.TIMEOUT_CYCLES(T)) dut (
      .req(req), .rst_n(rst_n), .in_valid(in_valid), .opcode_in(opcode_in),
      .funct3_in(funct3_in), .result_in(result_in), .rs2_value_in(rs2_value_in),
      .rd_in(rd_in), .stall_out(stall_out), .dmem_valid(dmem_valid),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_rd_write(wb_rd_write), .wb_rd(wb_rd),
      .wb_data(wb_data), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'h0, stall_out}, 32'h0);
      check({tag, "_dvalid"}, {31'h0, dmem_valid}, 32'h0);
      check({tag, "_we"}, {31'h0, dmem_we}, 32'h0);
      check({tag, "_addr"}, dmem_addr, 32'h0);
      check({tag, "_be"}, {28'h0, dmem_be}, 32'h0);
      check({tag, "_wdata"}, dmem_wdata, 32'h0);
      check({tag, "_wbv"}, {31'h0, wb_valid}, 32'h0);
      check({tag, "_wbw"}, {31'h0, wb_rd_write}, 32'h0);
      check({tag, "_wbrd"}, {27'h0, wb_rd}, 32'h0);
      check({tag, "_wbdata"}, wb_data, 32'h0);
      check({tag, "_mis"}, {31'h0, misalign_out}, 32'h0);
      check({tag, "_berr"}, {31'h0, bus_err_out}, 32'h0);
   endtask

   // One instruction from issue to writeback; lat = number of BUSY cycles before ready.
   task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [4:0] rd, input int lat,
                           input logic [31:0] rdata);
      int size;
      bit ld, st, legal;
      logic [31:0] exp_be, exp_wd, exp_ld, sh, mask;
      ld = (op == LD);
      st = (op == ST);
      size = 1 << f3[1:0];
      legal = (ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (st && f3 < 3'd3);
      legal = legal && ((addr % size) == 0);
      exp_be = ((32'd1 << size) - 32'd1) << (addr % 4);
      if (size == 1)      exp_wd = {24'h0, rs2[7:0]} * 32'h0101_0101;
      else if (size == 2) exp_wd = {16'h0, rs2[15:0]} * 32'h0001_0001;
      else                exp_wd = rs2;
      sh = rdata >> (8 * (addr % 4));
      mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      exp_ld = sh & mask;
      if (!f3[2] && size < 4 && sh[8 * size - 1]) exp_ld = exp_ld | ~mask;

      @(negedge req);
      in_valid = 1'b1; opcode_in = op; funct3_in = f3; result_in = addr;
      rs2_value_in = rs2; rd_in = rd; dmem_ready = 1'b0; dmem_rdata = $urandom;
      #1;
      check("stall_issue", {31'h0, stall_out}, {31'h0, (ld || st) && legal});
      @(posedge req); #1;
      if (!(ld || st)) begin
         check("pt_wbv", {31'h0, wb_valid}, 32'h1);
         check("pt_data", wb_data, addr);
         check("pt_rd", {27'h0, wb_rd}, {27'h0, rd});
         check("pt_wbw", {31'h0, wb_rd_write}, {31'h0, rd != 5'd0});
         check("pt_dvalid", {31'h0, dmem_valid}, 32'h0);
      end else if (!legal) begin
         check("mis_pulse", {31'h0, misalign_out}, 32'h1);
         check("mis_wbv", {31'h0, wb_valid}, 32'h1);
         check("mis_wbw", {31'h0, wb_rd_write}, 32'h0);
         check("mis_dvalid", {31'h0, dmem_valid}, 32'h0);
      end else begin
         for (int k = 0; k < T; k++) begin
            check("bus_valid", {31'h0, dmem_valid}, 32'h1);
            check("bus_we", {31'h0, dmem_we}, {31'h0, st});
            check("bus_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("bus_be", {28'h0, dmem_be}, exp_be);
            check("bus_wdata", dmem_wdata, st ? exp_wd : 32'h0);
            check("busy_wbv", {31'h0, wb_valid}, 32'h0);
            @(negedge req);
            dmem_ready = (k == lat);
            dmem_rdata = (k == lat) ? rdata : $urandom;
            #1;
            check("stall_busy", {31'h0, stall_out}, {31'h0, !(k == lat || k == T - 1)});
            @(posedge req); #1;
            if (k == lat) begin
               check("done_wbv", {31'h0, wb_valid}, 32'h1);
               check("done_wbw", {31'h0, wb_rd_write}, {31'h0, ld && rd != 5'd0});
               check("done_rd", {27'h0, wb_rd}, {27'h0, rd});
               if (ld) check("load_data", wb_data, exp_ld);
               check("done_dvalid", {31'h0, dmem_valid}, 32'h0);
               check("done_berr", {31'h0, bus_err_out}, 32'h0);
               break;
            end else if (k == T - 1) begin
               check("to_berr", {31'h0, bus_err_out}, 32'h1);
               check("to_wbv", {31'h0, wb_valid}, 32'h1);
               check("to_wbw", {31'h0, wb_rd_write}, 32'h0);
               check("to_dvalid", {31'h0, dmem_valid}, 32'h0);
            end else begin
               check("wait_berr", {31'h0, bus_err_out}, 32'h0);
            end
         end
      end
   endtask

   // Idle cycles with stray ready pulses that must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge req);
         in_valid = 1'b0; opcode_in = LD; funct3_in = 3'd2; result_in = $urandom & 32'hFFFF_FFFC;
         dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
         #1;
         check("idle_stall", {31'h0, stall_out}, 32'h0);
         @(posedge req); #1;
         check("idle_wbv", {31'h0, wb_valid}, 32'h0);
         check("idle_dvalid", {31'h0, dmem_valid}, 32'h0);
         check("idle_mis", {31'h0, misalign_out}, 32'h0);
         check("idle_berr", {31'h0, bus_err_out}, 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0]  op;
      logic [31:0] a;
      int          r;
      #12;
      check_all_zero("reset");
      @(negedge req); rst_n = 1'b1;

      do_instr(7'b0110011, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
      do_instr(LD, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 3, 32'h80FF_FF7F);
      do_instr(ST, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 1, 32'h0);
      do_instr(LD, 3'b010, 32'h0000_0301, 32'h0, 5'd3, 0, 32'h0);
      do_instr(ST, 3'b010, 32'h0000_0010, 32'h1234_5678, 5'd0, 99, 32'h0);
      do_instr(LD, 3'b101, 32'h0000_0412, 32'h0, 5'd4, 0, 32'h8001_7FFF);
      do_instr(LD, 3'b100, 32'h0000_0501, 32'h0, 5'd0, 2, 32'hAA55_F0C3);
      do_instr(LD, 3'b011, 32'h0000_0600, 32'h0, 5'd6, 0, 32'h0);
      do_instr(ST, 3'b100, 32'h0000_0700, 32'h0, 5'd6, 0, 32'h0);
      idle(2);

      @(negedge req);
      in_valid = 1'b1; opcode_in = LD; funct3_in = 3'b010; result_in = 32'h40;
      rd_in = 5'd8; dmem_ready = 1'b0;
      @(posedge req); #1;
      check("rst_pre_dvalid", {31'h0, dmem_valid}, 32'h1);
      @(negedge req);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("rst_busy");
      @(negedge req); rst_n = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(posedge req); #1;
      check("rst_ready_wbv", {31'h0, wb_valid}, 32'h0);
      check("rst_ready_dvalid", {31'h0, dmem_valid}, 32'h0);
      do_instr(LD, 3'b010, 32'h0, 32'h0, 5'd1, 0, 32'h1);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         op = 7'($urandom);
         if (op == LD || op == ST) op = 7'b0010011;
         if (r < 4) op = LD;
         else if (r < 7) op = ST;
         a = $urandom;
         do_instr(op, 3'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
